// File: rtl/spi_pkg.sv
// Shared constants, FSM state type and frame builder for the SPI register-protocol master.
package spi_pkg;

    localparam int FRAME_BITS     = 41;
    localparam int ADDR_W         = 7;
    localparam int DATA_W         = 32;
    localparam int WR_BIT         = 40;
    localparam int ADDR_MSB       = 39;
    localparam int ADDR_LSB       = 33;
    localparam int DATA_MSB       = 32;
    localparam int DATA_LSB       = 1;
    localparam int RD_FIRST_CYCLE = 9;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} spi_state_e;

    function automatic logic [FRAME_BITS-1:0] build_frame(input logic              wr,
                                                          input logic [ADDR_W-1:0] addr,
                                                          input logic [DATA_W-1:0] wdata);
        logic [FRAME_BITS-1:0] f;
        f                      = '0;
        f[WR_BIT]              = wr;
        f[ADDR_MSB:ADDR_LSB]   = addr;
        f[DATA_MSB:DATA_LSB]   = wr ? wdata : {DATA_W{1'b0}};
        return f;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// sclk phase generator: toggles sclk every CLK_DIV enabled cycles; strobes flag the cycle
// whose closing clk edge performs the rise or fall.
module spi_clk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int unsigned CNT_W = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap     = en && (cnt == CNT_W'(CLK_DIV - 1));
    assign rise_stb = wrap && !sclk;
    assign fall_stb = wrap && sclk;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (wrap) begin
            cnt  <= '0;
            sclk <= !sclk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator for 41-bit register frames {wr, addr, wdata, 0}; one command per
// valid/ready handshake, one rsp_valid pulse per completed frame.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_IDLE  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              sclk,
    output logic              cs,
    output logic              mosi,
    input  logic              miso
);

    if (CLK_DIV < 2) begin : g_clk_div_check
        $error("spi_master: CLK_DIV must be at least 2");
    end
    if (CS_SETUP < 1 || CS_HOLD < 1 || CS_IDLE < 1) begin : g_cs_timing_check
        $error("spi_master: CS_SETUP, CS_HOLD and CS_IDLE must be at least 1");
    end

    localparam int CNT_W = 16;

    spi_state_e              state;
    logic [CNT_W-1:0]        cnt;
    logic [5:0]              bit_cnt;
    logic [FRAME_BITS-2:0]   sreg;
    logic [DATA_W-1:0]       rx;
    logic                    wr_q;
    logic [FRAME_BITS-1:0]   frame;
    logic                    shift_en;
    logic                    rise_stb;
    logic                    fall_stb;

    assign frame    = build_frame(cmd_wr, cmd_addr, cmd_wdata);
    assign shift_en = (state == SHIFT);

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk     (clk),
        .rst     (rst),
        .en      (shift_en),
        .sclk    (sclk),
        .rise_stb(rise_stb),
        .fall_stb(fall_stb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cs        <= 1'b1;
            mosi      <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            cnt       <= '0;
            bit_cnt   <= '0;
            sreg      <= '0;
            rx        <= '0;
            wr_q      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        wr_q      <= cmd_wr;
                        mosi      <= frame[WR_BIT];
                        sreg      <= frame[FRAME_BITS-2:0];
                        cs        <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        cnt       <= CNT_W'(CS_SETUP);
                        bit_cnt   <= 6'(FRAME_BITS - 1);
                        rx        <= '0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == CNT_W'(1)) state <= SHIFT;
                    else                  cnt   <= cnt - 1'b1;
                end
                SHIFT: begin
                    // Only the last DATA_W sampled bits carry read data.
                    if (rise_stb && bit_cnt <= 6'(FRAME_BITS - 1 - RD_FIRST_CYCLE)) begin
                        rx <= {rx[DATA_W-2:0], miso};
                    end
                    if (fall_stb) begin
                        if (bit_cnt == '0) begin
                            mosi  <= 1'b0;
                            cnt   <= CNT_W'(CS_HOLD);
                            state <= HOLD;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                            mosi    <= sreg[FRAME_BITS-2];
                            sreg    <= {sreg[FRAME_BITS-3:0], 1'b0};
                        end
                    end
                end
                HOLD: begin
                    if (cnt == CNT_W'(1)) begin
                        cs        <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= wr_q ? '0 : rx;
                        cnt       <= CNT_W'(CS_IDLE - 1);
                        state     <= GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    // The first IDLE cycle still has cs high and completes the idle gap.
                    if (cnt <= CNT_W'(1)) begin
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master at CLK_DIV 4/2/8 against a behavioural SPI slave and a register-file
// reference model: table vectors, back-to-back, mid-frame reset and randomised commands.
module tb_spi_master;

    localparam logic [31:0] PRELOAD = 32'h12345678;

    logic        clk = 1'b0;
    logic [2:0]  rst = 3'b111;
    logic [2:0]  cmd_valid = 3'b000;
    logic        cmd_wr = 1'b0;
    logic [6:0]  cmd_addr = 7'h0;
    logic [31:0] cmd_wdata = 32'h0;
    logic [2:0]  cmd_ready, rsp_valid, busy, sclk, cs, mosi, miso;
    logic [31:0] rsp_rdata [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_master #(.CLK_DIV(4)) u_dut0 (
        .clk(clk), .rst(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid[0]),
        .rsp_rdata(rsp_rdata[0]), .busy(busy[0]), .sclk(sclk[0]), .cs(cs[0]), .mosi(mosi[0]),
        .miso(miso[0])
    );
    spi_master #(.CLK_DIV(2)) u_dut1 (
        .clk(clk), .rst(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid[1]),
        .rsp_rdata(rsp_rdata[1]), .busy(busy[1]), .sclk(sclk[1]), .cs(cs[1]), .mosi(mosi[1]),
        .miso(miso[1])
    );
    spi_master #(.CLK_DIV(8)) u_dut2 (
        .clk(clk), .rst(rst[2]), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
        .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid[2]),
        .rsp_rdata(rsp_rdata[2]), .busy(busy[2]), .sclk(sclk[2]), .cs(cs[2]), .mosi(mosi[2]),
        .miso(miso[2])
    );

    // Behavioural slave: oversamples sclk/cs, assembles the frame, serves reads, commits writes.
    logic [31:0] smem [3][128];
    logic [40:0] sfr [3];
    logic [40:0] last_frame [3];
    int          srises [3];
    int          last_rises [3];
    int          sidx [3];
    logic [2:0]  sclk_q, cs_q;
    logic        mem_init = 1'b1;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            sclk_q[i] <= sclk[i];
            cs_q[i]   <= cs[i];
            if (mem_init) begin
                for (int a = 0; a < 128; a++) smem[i][a] <= (i == 0 && a == 'h12) ? PRELOAD : 32'h0;
                srises[i] <= 0;
                sidx[i]   <= 0;
                sfr[i]    <= '0;
            end else if (cs_q[i] && !cs[i]) begin
                sidx[i]   <= 0;
                srises[i] <= 0;
                sfr[i]    <= '0;
                miso[i]   <= 1'($urandom);
            end else if (!cs_q[i] && cs[i]) begin
                last_frame[i] <= sfr[i];
                last_rises[i] <= srises[i];
                if (srises[i] == 41 && sfr[i][40]) smem[i][sfr[i][39:33]] <= sfr[i][32:1];
            end else if (!cs[i] && !sclk_q[i] && sclk[i]) begin
                sfr[i][40 - sidx[i]] <= mosi[i];
                srises[i]            <= srises[i] + 1;
            end else if (!cs[i] && sclk_q[i] && !sclk[i]) begin
                sidx[i] <= sidx[i] + 1;
                if (sidx[i] + 1 >= 9 && sidx[i] + 1 <= 40)
                    miso[i] <= smem[i][sfr[i][39:33]][31 - (sidx[i] - 8)];
                else
                    miso[i] <= 1'($urandom);
            end
        end
    end

    logic [31:0] ref_mem [3][128];

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 2 : 8;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input int i, input logic wr, input logic [6:0] addr,
                         input logic [31:0] wdata);
        int t = 0;
        @(negedge clk);
        cmd_wr       = wr;
        cmd_addr     = addr;
        cmd_wdata    = wdata;
        cmd_valid[i] = 1'b1;
        while (!cmd_ready[i] && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready[i]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: inst %0d cmd_ready=0 after %0d cycles, required 1", i, t);
        end
        @(posedge clk);
    endtask

    // Called just after the accept edge; lat counts clk edges from accept to rsp_valid.
    task automatic wait_rsp(input int i, output logic [31:0] rdata, output int lat);
        int n = 0;
        @(negedge clk);
        cmd_valid[i] = 1'b0;
        while (!rsp_valid[i] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid[i]) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: inst %0d rsp_valid=0 after %0d cycles, required 1", i, n);
            lat   = -1;
            rdata = 32'hx;
        end else begin
            lat   = n;
            rdata = rsp_rdata[i];
            check("busy at rsp", busy[i], 1);
            check("cs high at rsp", cs[i], 1);
            @(negedge clk);
            check("rsp_valid single cycle", rsp_valid[i], 0);
            check("mosi idle after frame", mosi[i], 0);
        end
    endtask

    task automatic run_cmd(input int i, input logic wr, input logic [6:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata);
        int          lat;
        logic [40:0] exp_frame;
        exp_frame = {wr, addr, wr ? wdata : 32'h0, 1'b0};
        issue(i, wr, addr, wdata);
        wait_rsp(i, rdata, lat);
        check("latency", lat, 2 + 82 * div_of(i) + 2);
        check("rdata vs model", rdata, wr ? 32'h0 : ref_mem[i][addr]);
        check("frame on mosi", last_frame[i], exp_frame);
        check("sclk pulse count", last_rises[i], 41);
        if (wr) ref_mem[i][addr] = wdata;
    endtask

    typedef struct {
        logic        wr;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] rd;
    int          n, cs_hi, seen;

    initial begin
        for (int i = 0; i < 3; i++)
            for (int a = 0; a < 128; a++) ref_mem[i][a] = (i == 0 && a == 'h12) ? PRELOAD : 32'h0;

        vecs[0] = '{1'b1, 7'h05, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 7'h12, 32'hFFFFFFFF, 32'h12345678};
        vecs[2] = '{1'b0, 7'h05, 32'h0,        32'hDEADBEEF};
        vecs[3] = '{1'b1, 7'h7F, 32'hCAFEF00D, 32'h0};
        vecs[4] = '{1'b0, 7'h7F, 32'h0,        32'hCAFEF00D};
        vecs[5] = '{1'b0, 7'h12, 32'hA5A5A5A5, 32'h12345678};

        repeat (3) @(negedge clk);
        rst      = 3'b000;
        mem_init = 1'b0;
        @(negedge clk);
        check("reset cs", cs[0], 1);
        check("reset sclk", sclk[0], 0);
        check("reset mosi", mosi[0], 0);
        check("reset cmd_ready", cmd_ready[0], 1);
        check("reset busy", busy[0], 0);
        check("reset rsp_valid", rsp_valid[0], 0);
        check("reset rsp_rdata", rsp_rdata[0], 0);
        check("reset cs all", cs, 3'b111);
        check("reset cmd_ready all", cmd_ready, 3'b111);

        for (int v = 0; v < 6; v++) begin
            run_cmd(0, vecs[v].wr, vecs[v].addr, vecs[v].wdata, rd);
            check("table rdata", rd, vecs[v].exp_rdata);
        end

        // Back-to-back with cmd_valid held: write then read of the same address.
        issue(0, 1'b1, 7'h33, 32'h0BADF00D);
        n     = 0;
        cs_hi = 0;
        seen  = 0;
        @(negedge clk);
        cmd_wr    = 1'b0;
        cmd_wdata = 32'h5555AAAA;
        while (!cmd_ready[0] && n < 2000) begin
            if (cs[0]) cs_hi++;
            if (rsp_valid[0]) seen++;
            @(negedge clk);
            n++;
        end
        if (cs[0]) cs_hi++;
        check("b2b accept spacing", n + 1, 336);
        check("b2b cs gap >= 4", cs_hi >= 4, 1);
        check("b2b first rsp seen", seen, 1);
        @(posedge clk);
        ref_mem[0][7'h33] = 32'h0BADF00D;
        wait_rsp(0, rd, n);
        check("b2b second latency", n, 332);
        check("b2b readback", rd, 32'h0BADF00D);

        // Reset during bit 20 of a read frame.
        issue(0, 1'b0, 7'h12, 32'h0);
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        @(negedge clk);
        n = 0;
        while (srises[0] < 21 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reached bit 20", srises[0], 21);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        check("mid reset cs", cs[0], 1);
        check("mid reset sclk", sclk[0], 0);
        check("mid reset rsp_valid", rsp_valid[0], 0);
        seen = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (rsp_valid[0]) seen++;
        end
        check("no rsp after reset", seen, 0);
        check("cmd_ready after reset", cmd_ready[0], 1);
        run_cmd(0, 1'b1, 7'h44, 32'h13572468, rd);
        run_cmd(0, 1'b0, 7'h44, 32'h0, rd);
        check("readback after reset", rd, 32'h13572468);

        // Integration at the extreme dividers.
        for (int i = 1; i < 3; i++) begin
            run_cmd(i, 1'b1, 7'h7F, 32'hCAFEF00D, rd);
            run_cmd(i, 1'b0, 7'h7F, 32'h0, rd);
            check("integration readback", rd, 32'hCAFEF00D);
        end

        // Randomised traffic against the reference register file.
        for (int k = 0; k < 24; k++) begin
            int          inst;
            logic        wr;
            logic [6:0]  addr;
            inst = int'($urandom_range(0, 1));
            wr   = 1'($urandom);
            addr = ($urandom_range(0, 3) == 0) ? 7'h12 : 7'($urandom_range(0, 7));
            run_cmd(inst, wr, addr, $urandom, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- AHB-side initiator for the 41-bit SPI register protocol. It takes one command at a time from the bridge through a valid/ready handshake.
- Generates cs, sclk and mosi for the SPI slave block, captures miso read data, and returns one response per command.
- Both ends run on the same clk. The slave oversamples sclk with clk.

Parameters:
- CLK_DIV, 4: sclk half-period in clk cycles. Legal minimum is 2.
- CS_SETUP, 2: clk cycles from cs falling to the first sclk rise phase.
- CS_HOLD, 2: clk cycles from the last sclk fall to cs rising.
- CS_IDLE, 4: minimum clk cycles cs stays high between frames, so the slave can commit the write.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, synchronous, active-high.
- cmd_valid, in, 1: command request.
- cmd_ready, out, 1: block can accept a command.
- cmd_wr, in, 1: 1 = write, 0 = read.
- cmd_addr, in, 7: register address.
- cmd_wdata, in, 32: write data. Ignored on reads.
- rsp_valid, out, 1: one-cycle pulse when a frame completes.
- rsp_rdata, out, 32: read data. 0 after writes.
- busy, out, 1: high from command accept until the end of the cs idle gap.
- sclk, out, 1: SPI clock, mode 0 (idle low).
- cs, out, 1: chip select, active-low.
- mosi, out, 1: serial data to the slave.
- miso, in, 1: serial data from the slave.

Behaviour:
- Reset values: cs=1, sclk=0, mosi=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0. The state machine returns to IDLE.
- Frame layout is frame[40:0] = {wr, addr[6:0], wdata[31:0], 1'b0}, shifted MSB first. This is exactly 41 sclk cycles, numbered 0..40.
- All outputs are registered.
- The command is accepted at a clk edge where cmd_valid && cmd_ready is true. The block latches wr, addr and wdata (wdata is forced to 0 on reads).
- cmd_ready is high only in IDLE. cmd_valid asserted while busy is held, not dropped.
- State machine:
  - IDLE: on accept, go to SETUP. cs=0, mosi=frame[40].
  - SETUP: stay CS_SETUP cycles with sclk=0, then go to SHIFT.
  - SHIFT: for each bit, sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
    - On the clk edge that drives sclk 0->1, sample miso.
    - On the clk edge that drives sclk 1->0, advance mosi to the next frame bit. After the last bit, hold mosi at 0.
    - After the 41st high phase, drive sclk=0 and go to HOLD.
  - HOLD: stay CS_HOLD cycles with cs=0, then drive cs=1, pulse rsp_valid for one cycle, and go to GAP.
  - GAP: stay CS_IDLE cycles with cs=1 and busy=1, then go to IDLE.
- Read capture: miso sampled at rising edges of sclk cycles 9..40 fills rsp_rdata[31] down to rsp_rdata[0]. Samples at cycles 0..8 are discarded.
- rsp_rdata updates in the same cycle rsp_valid asserts and holds until the next rsp_valid. On writes it is 0.
- Latency from accept to rsp_valid is CS_SETUP + 82*CLK_DIV + CS_HOLD cycles, which is 332 at defaults.
- Minimum accept-to-accept spacing is that latency plus CS_IDLE, which is 336 at defaults.
- Bit counter: 6-bit, loaded with 40, decremented after each falling phase. The frame ends when it reaches 0 after the falling phase.
- Reset mid-frame: next cycle cs=1 and sclk=0, no rsp_valid, and the in-flight command is lost.
- CLK_DIV < 2 is illegal. Reject it with an elaboration-time check.

Decomposition:
- Shared package spi_pkg holds:
  - constants FRAME_BITS=41, ADDR_W=7, DATA_W=32;
  - field positions WR_BIT=40, ADDR_MSB=39, ADDR_LSB=33, DATA_MSB=32, DATA_LSB=1;
  - RD_FIRST_CYCLE=9;
  - the state enum {IDLE, SETUP, SHIFT, HOLD, GAP}.
- One sub-module, spi_clk_gen. It is a CLK_DIV phase counter with enable. It outputs the registered sclk plus one-cycle rise_stb and fall_stb strobes aligned with the sclk transitions. spi_master instantiates it.

Test Plan:
- Write, addr=0x05, wdata=0xDEADBEEF, defaults:
  - mosi at the 41 sclk rises = 1, 0000101, 0xDEADBEEF MSB first, 0;
  - exactly 41 sclk pulses;
  - rsp_valid 332 cycles after accept, rsp_rdata=0.
- Read, addr=0x12, with a miso model driving 0x12345678 on cycles 9..40 (changing after each sclk fall):
  - rsp_rdata=0x12345678;
  - garbage driven on cycles 0..8 does not affect the result.
- Back-to-back: cmd_valid held high with two commands:
  - cmd_ready low throughout the first frame;
  - cs high for at least 4 cycles between frames;
  - second accept 336 cycles after the first.
- Reset asserted during bit 20 of a frame:
  - cs=1 and sclk=0 on the next cycle, no rsp_valid;
  - cmd_ready=1 afterwards;
  - a following write completes normally.
- Integration with the SPI slave block, CLK_DIV=2 and CLK_DIV=8: write 0xCAFEF00D to addr 0x7F, then read addr 0x7F, and rsp_rdata=0xCAFEF00D.
